// File: rtl/gate_truth_checker.sv
// Stimulus/response checker for a 2-input gate: walks a/b through 00,01,10,11,
// holds each vector HOLD_CYCLES cycles and compares c on the last hold cycle.
module gate_truth_checker #(
  parameter int unsigned HOLD_CYCLES = 100,
  parameter logic [1:0]  OP          = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       c,
  output logic       a,
  output logic       b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_APPLY   = 2'd1;
  localparam logic [1:0]  S_DONE    = 2'd2;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [1:0]  vec_q, vec_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [2:0]  err_q, err_d;
  logic [1:0]  ff_q, ff_d;

  logic exp_v;
  logic at_cmp;
  logic mismatch;

  always_comb begin
    exp_v = 1'b0;
    case (OP)
      2'b00:   exp_v = vec_q[1] & vec_q[0];
      2'b01:   exp_v = vec_q[1] | vec_q[0];
      2'b10:   exp_v = vec_q[1] ^ vec_q[0];
      default: exp_v = ~(vec_q[1] & vec_q[0]);
    endcase
  end

  // c is only trusted on the last hold cycle; earlier cycles are settle time.
  assign at_cmp   = (state_q == S_APPLY) && (hold_q == HOLD_LAST);
  assign mismatch = at_cmp && (c != exp_v);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          hold_d  = 16'd0;
          vec_d   = 2'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = 3'd0;
          ff_d    = 2'd0;
        end
      end
      S_APPLY: begin
        if (mismatch) begin
          err_d = err_q + 3'd1;
          if (err_q == 3'd0) ff_d = vec_q;
        end
        if (at_cmp) begin
          hold_d = 16'd0;
          if (vec_q == 2'd3) begin
            // pass uses the count including this cycle's vector-3 decision
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 3'd0);
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        hold_d  = 16'd0;
        vec_d   = 2'd0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        err_d   = 3'd0;
        ff_d    = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= 16'd0;
      vec_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      ff_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  assign a          = vec_q[1];
  assign b          = vec_q[0];
  assign vec_idx    = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three checkers (OR, NAND, AND) watch a shared
// behavioural gate whose flavour is selected by mode; a timing model predicts outputs.
module tb_gate_truth_checker;

  localparam int H = 4;
  localparam int NI = 3;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err;
    logic [1:0] ff;
    logic [1:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   mode = 0;

  logic [NI-1:0]      a_v, b_v, c_v, busy_v, done_v, pass_v;
  logic [NI-1:0][1:0] vec_v, ff_v;
  logic [NI-1:0][2:0] err_v;
  logic [1:0]         op_v [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // instance 0: OR, 1: NAND, 2: AND
  initial begin
    op_v[0] = 2'b01;
    op_v[1] = 2'b11;
    op_v[2] = 2'b00;
  end

  gate_truth_checker #(.HOLD_CYCLES(H), .OP(2'b01)) u_or (
    .clk(clk), .rst_n(rst_n), .start(start), .c(c_v[0]), .a(a_v[0]), .b(b_v[0]),
    .vec_idx(vec_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err_v[0]), .first_fail(ff_v[0]));

  gate_truth_checker #(.HOLD_CYCLES(H), .OP(2'b11)) u_nand (
    .clk(clk), .rst_n(rst_n), .start(start), .c(c_v[1]), .a(a_v[1]), .b(b_v[1]),
    .vec_idx(vec_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err_v[1]), .first_fail(ff_v[1]));

  gate_truth_checker #(.HOLD_CYCLES(H), .OP(2'b00)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start), .c(c_v[2]), .a(a_v[2]), .b(b_v[2]),
    .vec_idx(vec_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(err_v[2]), .first_fail(ff_v[2]));

  function automatic logic gate_fn(input logic [1:0] op, input logic [1:0] v);
    case (op)
      2'b00:   return v[1] & v[0];
      2'b01:   return v[1] | v[0];
      2'b10:   return v[1] ^ v[0];
      default: return ~(v[1] & v[0]);
    endcase
  endfunction

  // gate under test: 0 good OR, 1 stuck-at-0, 2 inverted OR, 3 NAND
  function automatic logic dut_fn(input int m, input logic [1:0] v);
    case (m)
      0:       return v[1] | v[0];
      1:       return 1'b0;
      2:       return ~(v[1] | v[0]);
      default: return ~(v[1] & v[0]);
    endcase
  endfunction

  always_comb begin
    c_v = '0;
    for (int i = 0; i < NI; i++) c_v[i] = dut_fn(mode, {a_v[i], b_v[i]});
  end

  // Model: a run started at edge k shows vector t/H at edge k+t, finishes at k+4H.
  int             cyc = 0;
  int             k_q = 0;
  logic           have_run = 1'b0;
  logic [NI-1:0][3:0] mask_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_run <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (start && !(have_run && (cyc - k_q) < 4 * H)) begin
        have_run <= 1'b1;
        k_q      <= cyc + 1;
        for (int i = 0; i < NI; i++)
          for (int n = 0; n < 4; n++)
            mask_q[i][n] <= (dut_fn(mode, 2'(n)) != gate_fn(op_v[i], 2'(n)));
      end
    end
  end

  function automatic exp_t model_out(input logic run, input int t, input logic [3:0] m);
    exp_t r;
    int   nv;
    r = '0;
    if (!run) return r;
    if (t < 4 * H) begin
      r.busy = 1'b1;
      nv     = t / H;
      r.vec  = 2'(nv);
    end else begin
      r.done = 1'b1;
      r.vec  = 2'd3;
      nv     = 4;
    end
    for (int n = 0; n < nv; n++) begin
      if (m[n]) begin
        if (r.err == 3'd0) r.ff = 2'(n);
        r.err = r.err + 3'd1;
      end
    end
    r.pass = r.done && (r.err == 3'd0);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      e = model_out(have_run, cyc - k_q, mask_q[i]);
      chk($sformatf("u%0d.busy", i), busy_v[i], e.busy);
      chk($sformatf("u%0d.done", i), done_v[i], e.done);
      chk($sformatf("u%0d.pass", i), pass_v[i], e.pass);
      chk($sformatf("u%0d.err_count", i), err_v[i], e.err);
      chk($sformatf("u%0d.first_fail", i), ff_v[i], e.ff);
      chk($sformatf("u%0d.vec_idx", i), vec_v[i], e.vec);
      chk($sformatf("u%0d.a", i), a_v[i], e.vec[1]);
      chk($sformatf("u%0d.b", i), b_v[i], e.vec[0]);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // leaves the bench at the negedge following the accepting edge k
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst.busy", busy_v[0], 0);
    chk("rst.vec", vec_v[0], 0);
    wait_n(2);
    rst_n = 1'b1;
    wait_n(2);

    // good OR gate
    mode = 0;
    pulse_start();
    chk("or.k.busy", busy_v[0], 1);
    wait_n(4);  chk("or.k4.ab", {a_v[0], b_v[0]}, 1);
    wait_n(4);  chk("or.k8.ab", {a_v[0], b_v[0]}, 2);
    wait_n(4);  chk("or.k12.ab", {a_v[0], b_v[0]}, 3);
    wait_n(3);  chk("or.k15.done", done_v[0], 0);
    wait_n(1);
    chk("or.k16.done", done_v[0], 1);
    chk("or.k16.pass", pass_v[0], 1);
    chk("or.k16.err", err_v[0], 0);
    wait_n(2);

    // stuck-at-0, started from DONE
    mode = 1;
    pulse_start();
    chk("sa0.k.done", done_v[0], 0);
    chk("sa0.k.vec", vec_v[0], 0);
    wait_n(16);
    chk("sa0.err", err_v[0], 3);
    chk("sa0.ff", ff_v[0], 1);
    chk("sa0.pass", pass_v[0], 0);
    chk("sa0.done", done_v[0], 1);
    wait_n(2);

    // inverted OR
    mode = 2;
    pulse_start();
    wait_n(16);
    chk("inv.err", err_v[0], 4);
    chk("inv.ff", ff_v[0], 0);
    chk("inv.pass", pass_v[0], 0);
    wait_n(2);

    // NAND gate against NAND and AND checkers
    mode = 3;
    pulse_start();
    wait_n(16);
    chk("nand.pass", pass_v[1], 1);
    chk("and.err", err_v[2], 4);
    wait_n(2);

    // ignored start mid-run, then reset in vector 2
    mode = 0;
    pulse_start();
    wait_n(5);
    start = 1'b1;
    wait_n(1);
    start = 1'b0;
    wait_n(2);  chk("ign.k8.vec", vec_v[0], 2);
    wait_n(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", busy_v[0], 0);
    chk("arst.vec", vec_v[0], 0);
    chk("arst.a", a_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(2);
    pulse_start();
    wait_n(16);
    chk("rerun.pass", pass_v[0], 1);
    chk("rerun.done", done_v[0], 1);
    wait_n(2);

    // start held high: back-to-back runs with a one-cycle done
    start = 1'b1;
    @(negedge clk);
    wait_n(16); chk("hold.k16.done", done_v[0], 1);
    wait_n(1);
    chk("hold.k17.done", done_v[0], 0);
    chk("hold.k17.busy", busy_v[0], 1);
    chk("hold.k17.vec", vec_v[0], 0);
    wait_n(16); chk("hold.k33.done", done_v[0], 1);
    start = 1'b0;
    wait_n(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
